vga_fill_arbiter: RTL and testbench
===================================

# vga_fill_arbiter

Frame-fill scheduler that owns the VGA pixel FIFO write port and shares it between two pixel sources: a background generator and a rectangular overlay. On each `vtrigger` pulse it walks the 640x480 raster in order. For each coordinate it selects the background or the overlay source, takes one pixel via a valid/ready handshake, and writes it to the VGA FIFO, honouring `fifo_full` backpressure. It sits between the pixel generators and the `vga` block in the system clock domain, replacing the free-running x/y fill logic in the top level.

## Interface
- `H_PIXELS`, 640, active pixels per line
- `V_LINES`, 480, active lines per frame
- `XW`, 10, x coordinate width (must cover `H_PIXELS-1`)
- `YW`, 9, y coordinate width (must cover `V_LINES-1`)
- `DATA_W`, 16, pixel width (RGB565)

- `clk` in 1: system clock (100 MHz); the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `vtrigger` in 1: one-cycle start-of-frame request from `vga`.
- `fifo_full` in 1: VGA FIFO full flag, with at least 2 entries of slack.
- `fifo_write` out 1: FIFO write strobe (registered).
- `fifo_data` out DATA_W: FIFO write data (registered).
- `ov_x0`, `ov_x1` in XW: inclusive overlay column bounds.
- `ov_y0`, `ov_y1` in YW: inclusive overlay row bounds.
- `pix_x` out XW, `pix_y` out YW: coordinate of the pixel currently requested.
- `sof` out 1: one-cycle pulse at frame (re)start; both sources flush on it.
- `bg_valid` in 1, `bg_data` in DATA_W, `bg_ready` out 1: background source handshake.
- `ov_valid` in 1, `ov_data` in DATA_W, `ov_ready` out 1: overlay source handshake.
- `frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `underrun` out 1: one-cycle pulse when `vtrigger` arrives mid-frame.

## Operation
- States: IDLE and FILL.
  - IDLE --`vtrigger`--> FILL.
  - FILL --last pixel accepted--> IDLE.
  - FILL --`vtrigger`--> FILL (restart).
- On entry to FILL:
  - x and y are cleared to 0.
  - `sof` is pulsed.
  - `ov_x0/x1/y0/y1` are latched; the window stays constant for the whole frame.
- Source select: `in_win = (x0<=x<=x1) && (y0<=y<=y1)` on the latched bounds. If x1<x0 or y1<y0 the window is empty and every pixel goes to the background source.
- Ready rules:
  - `bg_ready = FILL && !in_win && !fifo_full`
  - `ov_ready = FILL && in_win && !fifo_full`
  - At most one ready is high in any cycle.
  - The unselected source is never consumed, so each source sees only the pixels it owns, in raster order.
- Accept: the selected source's valid and ready are both high. Accept registers the source data into `fifo_data`, sets `fifo_write` for one cycle, and advances the counters.
- Counter advance:
  - x increments, wrapping to 0 at `H_PIXELS-1`.
  - y increments on the x wrap.
  - Accepting (`H_PIXELS-1`, `V_LINES-1`) pulses `frame_done` and returns to IDLE.
- `fifo_full` high: no ready is asserted and the counters hold. Selected valid low: stall with no write.
- `vtrigger` in FILL: pulse `underrun`, restart at (0,0), pulse `sof`, re-latch the window. A pixel accepted in the same cycle is still written; the counter advance is overridden by the restart.
- `vtrigger` in the same cycle as the final accept: `frame_done` pulses, there is no `underrun`, and FILL restarts.
- `pix_x`/`pix_y` show the current counters; they are 0 in IDLE.

## Timing
- Reset values: state IDLE, `fifo_write`=0, `fifo_data`=0, counters 0, `sof`/`frame_done`/`underrun`=0, window registers 0.
- `vtrigger` at cycle t: `sof`=1 and FILL in t+1. The first ready can go high in t+1.
- Accept in cycle t: `fifo_write`=1 with the data in t+1; counters advance in t+1.
- Throughput: 1 pixel/cycle when the selected valid is high and `fifo_full` is low.
- `fifo_full` is used combinationally in ready. The FIFO's 2-entry slack absorbs the registered write in flight.
- Reset asserted mid-frame: immediate return to IDLE with all outputs at reset values. No `frame_done` or `underrun` is generated.

## Structure
- Shared package `vga_pkg`:
  - `H_PIXELS` and `V_LINES` defaults.
  - `rgb565_t` pixel typedef.
  - `fill_state_t` enum {IDLE, FILL}.
- Sub-module `raster_counter`: x/y counter with clear, enable and wrap; outputs x, y and `last`. Reused by any later per-frame sequencer.
- The window compare and arbitration stay inline in `vga_fill_arbiter`.

## Test plan
- Empty window (x1=0,x0=1), bg always valid, no full:
  - 307200 writes in 307200 consecutive cycles after `sof`.
  - `frame_done` one cycle after the last accept.
  - `ov_ready` never high.
- Window (8,8)-(15,15), both sources always valid:
  - Exactly 64 `ov` accepts, at (8..15,8..15).
  - Written data matches `ov_data` there and `bg_data` elsewhere.
- `fifo_full` toggled every 3 cycles: no ready or write during full, no pixel dropped or duplicated, frame total still 307200.
- `vtrigger` at pixel (100,5): `underrun` pulse, `sof`, counters back to (0,0), new frame completes normally.
- `reset` asserted at pixel (320,240): all outputs 0 next cycle, state IDLE, no `frame_done`. The next `vtrigger` starts cleanly.
- `vtrigger` in the same cycle as the final accept: `frame_done`=1, `underrun`=0, new frame starts.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA fill path: default raster size, pixel type and fill states.
package vga_pkg;
   localparam int H_PIXELS = 640;
   localparam int V_LINES  = 480;

   typedef logic [15:0] rgb565_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;
endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter; clear has priority over enable, last flags the final coordinate.
module raster_counter #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last
);
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   assign last = (x == X_LAST) && (y == Y_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x <= '0;
         y <= '0;
      end else if (clear) begin
         x <= '0;
         y <= '0;
      end else if (enable) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end
endmodule

// File: rtl/vga_fill_arbiter.sv
// Frame-fill scheduler: walks the raster on vtrigger and feeds the VGA FIFO from either
// the background source or the overlay window source, one pixel per accept.
//
// state | meaning
// IDLE  | waiting for vtrigger, no source is consumed
// FILL  | walking the raster, one accepted pixel per FIFO write
module vga_fill_arbiter #(
   parameter int H_PIXELS = vga_pkg::H_PIXELS,
   parameter int V_LINES  = vga_pkg::V_LINES,
   parameter int XW       = 10,
   parameter int YW       = 9,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vtrigger,
   input  logic              fifo_full,
   output logic              fifo_write,
   output logic [DATA_W-1:0] fifo_data,
   input  logic [XW-1:0]     ov_x0,
   input  logic [XW-1:0]     ov_x1,
   input  logic [YW-1:0]     ov_y0,
   input  logic [YW-1:0]     ov_y1,
   output logic [XW-1:0]     pix_x,
   output logic [YW-1:0]     pix_y,
   output logic              sof,
   input  logic              bg_valid,
   input  logic [DATA_W-1:0] bg_data,
   output logic              bg_ready,
   input  logic              ov_valid,
   input  logic [DATA_W-1:0] ov_data,
   output logic              ov_ready,
   output logic              frame_done,
   output logic              underrun
);
   import vga_pkg::fill_state_t;
   import vga_pkg::IDLE;
   import vga_pkg::FILL;

   fill_state_t   state;
   logic [XW-1:0] win_x0, win_x1;
   logic [YW-1:0] win_y0, win_y1;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          last, filling, in_win, accept;

   assign filling  = (state == FILL);
   // an inverted bound pair can never satisfy both compares, so the window is empty
   assign in_win   = (x >= win_x0) && (x <= win_x1) && (y >= win_y0) && (y <= win_y1);
   assign bg_ready = filling && !in_win && !fifo_full;
   assign ov_ready = filling &&  in_win && !fifo_full;
   assign accept   = (bg_ready && bg_valid) || (ov_ready && ov_valid);
   assign pix_x    = x;
   assign pix_y    = y;

   raster_counter #(
      .H_PIXELS (H_PIXELS),
      .V_LINES  (V_LINES),
      .XW       (XW),
      .YW       (YW)
   ) u_raster (
      .clk    (clk),
      .reset  (reset),
      .clear  (vtrigger),
      .enable (accept),
      .x      (x),
      .y      (y),
      .last   (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         fifo_write <= 1'b0;
         fifo_data  <= '0;
         sof        <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         win_x0     <= '0;
         win_x1     <= '0;
         win_y0     <= '0;
         win_y1     <= '0;
      end else begin
         fifo_write <= accept;
         if (accept)
            fifo_data <= in_win ? ov_data : bg_data;
         sof        <= vtrigger;
         frame_done <= accept && last;
         // a trigger landing on the final accept is a clean back-to-back frame
         underrun   <= vtrigger && filling && !(accept && last);
         if (vtrigger) begin
            state  <= FILL;
            win_x0 <= ov_x0;
            win_x1 <= ov_x1;
            win_y0 <= ov_y0;
            win_y1 <= ov_y1;
         end else if (accept && last) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_vga_fill_arbiter.sv
// Randomized bench for vga_fill_arbiter against a linear pixel-index reference model.
module tb_vga_fill_arbiter;
   localparam int H = 24;
   localparam int V = 18;
   localparam int N = H * V;

   logic        clk = 1'b0;
   logic        reset, vtrigger, fifo_full;
   logic        fifo_write;
   logic [15:0] fifo_data;
   logic [9:0]  ov_x0, ov_x1, pix_x;
   logic [8:0]  ov_y0, ov_y1, pix_y;
   logic        sof, bg_valid, bg_ready, ov_valid, ov_ready, frame_done, underrun;
   logic [15:0] bg_data, ov_data;

   always #5 clk = ~clk;

   vga_fill_arbiter #(.H_PIXELS(H), .V_LINES(V), .XW(10), .YW(9), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .vtrigger(vtrigger), .fifo_full(fifo_full),
      .fifo_write(fifo_write), .fifo_data(fifo_data),
      .ov_x0(ov_x0), .ov_x1(ov_x1), .ov_y0(ov_y0), .ov_y1(ov_y1),
      .pix_x(pix_x), .pix_y(pix_y), .sof(sof),
      .bg_valid(bg_valid), .bg_data(bg_data), .bg_ready(bg_ready),
      .ov_valid(ov_valid), .ov_data(ov_data), .ov_ready(ov_ready),
      .frame_done(frame_done), .underrun(underrun)
   );

   int n_checks = 0;
   int n_errors = 0;

   // stimulus knobs
   int g_x0, g_x1, g_y0, g_y1;
   int bg_pct, ov_pct, full_mode;
   bit rand_win;
   int cyc = 0;

   // reference model: linear pixel index plus expected registered outputs
   bit          m_active;
   int          m_p, m_x0, m_x1, m_y0, m_y1;
   bit          m_wr, m_sof, m_done, m_under;
   logic [15:0] m_data;

   // observed event counters
   int n_wr, n_done, n_under, n_ov_acc, n_ov_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic clear_counts();
      n_wr = 0; n_done = 0; n_under = 0; n_ov_acc = 0; n_ov_rdy = 0;
   endtask

   task automatic step(input bit trig, input bit rst_in);
      int cx, cy;
      bit inw, e_bg, e_ov, acc, lastp;
      if (rand_win) begin
         g_x0 = $urandom_range(H + 2); g_x1 = $urandom_range(H + 2);
         g_y0 = $urandom_range(V + 2); g_y1 = $urandom_range(V + 2);
      end
      reset    = rst_in;
      vtrigger = trig;
      ov_x0    = g_x0[9:0]; ov_x1 = g_x1[9:0];
      ov_y0    = g_y0[8:0]; ov_y1 = g_y1[8:0];
      bg_valid = ($urandom_range(99) < bg_pct);
      ov_valid = ($urandom_range(99) < ov_pct);
      bg_data  = 16'($urandom);
      ov_data  = 16'($urandom);
      case (full_mode)
         1:       fifo_full = ((cyc / 3) % 2) == 1;
         2:       fifo_full = ($urandom_range(99) < 30);
         default: fifo_full = 1'b0;
      endcase
      if (rst_in) begin
         m_active = 0; m_p = 0; m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0;
         m_wr = 0; m_sof = 0; m_done = 0; m_under = 0; m_data = '0;
      end
      #2;
      cx    = m_p % H;
      cy    = m_p / H;
      inw   = m_active && cx >= m_x0 && cx <= m_x1 && cy >= m_y0 && cy <= m_y1;
      e_bg  = m_active && !inw && !fifo_full;
      e_ov  = m_active &&  inw && !fifo_full;
      acc   = (e_bg && bg_valid) || (e_ov && ov_valid);
      lastp = (m_p == N - 1);
      check("pix_x", 32'(pix_x), 32'(cx));
      check("pix_y", 32'(pix_y), 32'(cy));
      check("bg_ready", 32'(bg_ready), 32'(e_bg));
      check("ov_ready", 32'(ov_ready), 32'(e_ov));
      if (ov_ready) n_ov_rdy++;
      if (ov_ready && ov_valid) n_ov_acc++;
      if (!rst_in) begin
         m_wr    = acc;
         if (acc) m_data = inw ? ov_data : bg_data;
         m_sof   = trig;
         m_done  = acc && lastp;
         m_under = trig && m_active && !(acc && lastp);
         if (trig) begin
            m_active = 1; m_p = 0;
            m_x0 = g_x0; m_x1 = g_x1; m_y0 = g_y0; m_y1 = g_y1;
         end else if (acc) begin
            if (lastp) begin
               m_active = 0; m_p = 0;
            end else begin
               m_p++;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("fifo_write", 32'(fifo_write), 32'(m_wr));
      check("fifo_data", 32'(fifo_data), 32'(m_data));
      check("sof", 32'(sof), 32'(m_sof));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("underrun", 32'(underrun), 32'(m_under));
      if (fifo_write) n_wr++;
      if (frame_done) n_done++;
      if (underrun)   n_under++;
   endtask

   task automatic run_frame(input string tag, input int budget);
      int i;
      i = 0;
      while (m_active && i < budget) begin
         step(0, 0);
         i++;
      end
      check({tag, "_frame_end"}, 32'(m_active), 32'(0));
      check({tag, "_done_cnt"}, 32'(n_done), 32'(1));
   endtask

   task automatic run_to(input string tag, input int target, input int budget);
      int i;
      i = 0;
      while (m_p != target && i < budget) begin
         step(0, 0);
         i++;
      end
      check({tag, "_reached"}, 32'(m_p), 32'(target));
   endtask

   initial begin
      reset = 1; vtrigger = 0; fifo_full = 0;
      bg_valid = 0; ov_valid = 0; bg_data = 0; ov_data = 0;
      ov_x0 = 0; ov_x1 = 0; ov_y0 = 0; ov_y1 = 0;
      g_x0 = 1; g_x1 = 0; g_y0 = 0; g_y1 = 0;
      bg_pct = 100; ov_pct = 100; full_mode = 0; rand_win = 0;
      repeat (3) @(posedge clk);
      #1;
      step(0, 1);
      step(0, 0);
      step(0, 0);

      // empty window, back-to-back background pixels
      clear_counts();
      step(1, 0);
      check("empty_sof", 32'(sof), 32'(1));
      repeat (N) step(0, 0);
      check("empty_writes", 32'(n_wr), 32'(N));
      check("empty_done", 32'(n_done), 32'(1));
      check("empty_ov_rdy", 32'(n_ov_rdy), 32'(0));
      step(0, 0);

      // 8x8 overlay window
      g_x0 = 8; g_x1 = 15; g_y0 = 8; g_y1 = 15;
      clear_counts();
      step(1, 0);
      repeat (N) step(0, 0);
      check("win_ov_acc", 32'(n_ov_acc), 32'(64));
      check("win_writes", 32'(n_wr), 32'(N));
      check("win_done", 32'(n_done), 32'(1));

      // fifo_full toggling every 3 cycles
      full_mode = 1;
      g_x0 = 3; g_x1 = 10; g_y0 = 2; g_y1 = 6;
      clear_counts();
      step(1, 0);
      run_frame("full", 4 * N);
      check("full_writes", 32'(n_wr), 32'(N));

      // mid-frame retrigger at (10,5)
      full_mode = 2; bg_pct = 70; ov_pct = 70;
      clear_counts();
      step(1, 0);
      run_to("retrig", 5 * H + 10, 8 * N);
      step(1, 0);
      check("retrig_under", 32'(n_under), 32'(1));
      check("retrig_pix_x", 32'(pix_x), 32'(0));
      check("retrig_pix_y", 32'(pix_y), 32'(0));
      clear_counts();
      run_frame("retrig", 8 * N);

      // reset in the middle of a frame at (12,9)
      full_mode = 0; bg_pct = 100; ov_pct = 100;
      clear_counts();
      step(1, 0);
      run_to("rst", 9 * H + 12, 2 * N);
      step(0, 1);
      check("rst_write", 32'(fifo_write), 32'(0));
      check("rst_pix", 32'({pix_x, pix_y}), 32'(0));
      step(0, 0);
      step(0, 0);
      check("rst_no_done", 32'(n_done), 32'(0));
      check("rst_no_under", 32'(n_under), 32'(0));
      clear_counts();
      step(1, 0);
      run_frame("rst_restart", 2 * N);

      // trigger coinciding with the final accept
      clear_counts();
      step(1, 0);
      run_to("edge", N - 1, 2 * N);
      step(1, 0);
      check("edge_done", 32'(frame_done), 32'(1));
      check("edge_under", 32'(underrun), 32'(0));
      check("edge_sof", 32'(sof), 32'(1));
      clear_counts();
      run_frame("edge_next", 2 * N);

      // random stress with live-changing window inputs
      rand_win = 1; full_mode = 2; bg_pct = 80; ov_pct = 80;
      for (int i = 0; i < 3000; i++)
         step(($urandom_range(499) == 0) || (i == 0), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
